// File: rtl/btn_pkg.sv
// Shared types for the push-button front end: per-channel debounce states
// and synchroniser depth.
package btn_pkg;

  typedef enum logic [1:0] {
    DEB_IDLE    = 2'd0,
    DEB_PRESS   = 2'd1,
    DEB_HELD    = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, qualification counter and FSM.
// Produces a glitch-free active-low level plus a one-cycle press pulse.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int  DEB_CYCLES = 4,
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_n_i,
  input  logic       block_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       qual_o,
  output deb_state_t state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_n;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   qual;

  assign s_n = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    qual    = 1'b0;
    unique case (state_q)
      DEB_IDLE: begin
        level_d = 1'b1;
        cnt_d   = '0;
        if (!s_n) begin
          state_d = DEB_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (s_n) begin
          state_d = DEB_IDLE;
          cnt_d   = '0;
        end else if (block_i) begin
          // Other channel owns the button bus: stay pending, restart count.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_HELD;
          level_d = 1'b0;
          pulse_d = 1'b1;
          qual    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEB_HELD: begin
        level_d = 1'b0;
        if (s_n) begin
          state_d = DEB_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      DEB_RELEASE: begin
        if (!s_n) begin
          state_d = DEB_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_IDLE;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DEB_IDLE;
        level_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      state_q <= DEB_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign qual_o  = qual;
  assign state_o = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Two debounced button channels feeding the scoring controller.
// Define BTN_LOCKOUT_EN for A-priority mutual exclusion between channels.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ba_raw_n,
  input  logic bb_raw_n,
  output logic Ba,
  output logic Bb,
  output logic press_a,
  output logic press_b
);

  deb_state_t state_a, state_b;
  logic       qual_a, qual_b;
  logic       block_a, block_b;

`ifdef BTN_LOCKOUT_EN
  // A blocks B also on the edge A qualifies, so a tie always goes to A.
  assign block_a = (state_b == DEB_HELD) || (state_b == DEB_RELEASE);
  assign block_b = (state_a == DEB_HELD) || (state_a == DEB_RELEASE) || qual_a;
  logic unused_lockout;
  assign unused_lockout = qual_b;
`else
  assign block_a = 1'b0;
  assign block_b = 1'b0;
  logic unused_lockout;
  assign unused_lockout = ^{qual_a, qual_b, state_a, state_b};
`endif

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .raw_n_i (ba_raw_n),
    .block_i (block_a),
    .level_o (Ba),
    .pulse_o (press_a),
    .qual_o  (qual_a),
    .state_o (state_a)
  );

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .raw_n_i (bb_raw_n),
    .block_i (block_b),
    .level_o (Bb),
    .pulse_o (press_b),
    .qual_o  (qual_b),
    .state_o (state_b)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected {Ba,Bb,press_a,press_b} per edge
// from a sample-run reference model; a monitor pops and compares each cycle.
module tb_button_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ba_raw_n = 1'b1;
  logic bb_raw_n = 1'b1;
  logic Ba, Bb, press_a, press_b;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

`ifdef BTN_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  button_conditioner #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .ba_raw_n (ba_raw_n),
    .bb_raw_n (bb_raw_n),
    .Ba       (Ba),
    .Bb       (Bb),
    .press_a  (press_a),
    .press_b  (press_b)
  );

  always #5 clk = ~clk;

  // Reference model: each button's raw value reaches the decision two edges
  // late; a level flips after DEB consecutive opposing samples.
  logic [1:0] dly_a = 2'b11, dly_b = 2'b11;
  logic       lvl_a = 1'b1, lvl_b = 1'b1;
  int         run_a = 0, run_b = 0;
  bit         pend_a = 0, pend_b = 0;

  function automatic void chan(input logic s, input bit blocked, inout logic lvl,
                               inout int run, inout bit pend, output bit fell);
    fell = 1'b0;
    if (lvl) begin
      if (s) begin pend = 0; run = 0; end
      else if (!pend) begin pend = 1; run = 1; end
      else if (blocked) run = 0;
      else begin
        run++;
        if (run == DEB) begin lvl = 1'b0; run = 0; pend = 0; fell = 1'b1; end
      end
    end else begin
      if (!s) run = 0;
      else begin
        run++;
        if (run == DEB) begin lvl = 1'b1; run = 0; end
      end
    end
  endfunction

  task automatic step(input logic ra, input logic rb, input logic rs);
    logic sa, sb, pre_a, pre_b;
    bit   fa, fb;
    @(negedge clk);
    ba_raw_n = ra;
    bb_raw_n = rb;
    reset    = rs;
    fa = 0; fb = 0;
    if (rs) begin
      dly_a = 2'b11; dly_b = 2'b11;
      lvl_a = 1'b1;  lvl_b = 1'b1;
      run_a = 0; run_b = 0; pend_a = 0; pend_b = 0;
    end else begin
      sa = dly_a[1]; sb = dly_b[1];
      dly_a = {dly_a[0], ra};
      dly_b = {dly_b[0], rb};
      pre_a = lvl_a; pre_b = lvl_b;
      chan(sa, LOCK && !pre_b, lvl_a, run_a, pend_a, fa);
      chan(sb, LOCK && (!pre_a || fa), lvl_b, run_b, pend_b, fb);
    end
    exp_q.push_back({lvl_a, lvl_b, logic'(fa), logic'(fb)});
  endtask

  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({Ba, Bb, press_a, press_b} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {Ba,Bb,pa,pb} got=%b exp=%b", $time,
                 {Ba, Bb, press_a, press_b}, e);
      end
    end
  end

  initial begin
    logic ta, tb;
    int   ha, hb;
    // 1: reset with both held, then release reset with A still held
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // 2: clean press, long hold, release
    repeat (100) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // 3: bounce 0,1,0,1,0 then steady low
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    // 4: two-cycle high glitch while held
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // 5: simultaneous press, release A first with B still held
    repeat (20) step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // 6: reset during release count, then a fresh press
    repeat (10) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    // Random bouncy buttons with occasional reset
    ta = 1'b1; tb = 1'b1; ha = 0; hb = 0;
    for (int i = 0; i < 3000; i++) begin
      logic ra, rb, rs;
      if (ha == 0) begin ta = ~ta; ha = $urandom_range(3, 30); end else ha--;
      if (hb == 0) begin tb = ~tb; hb = $urandom_range(3, 30); end else hb--;
      ra = ($urandom_range(0, 9) < 2) ? ~ta : ta;
      rb = ($urandom_range(0, 9) < 2) ? ~tb : tb;
      rs = ($urandom_range(0, 399) == 0);
      step(ra, rb, rs);
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
